// File: rtl/typing_pkg.sv
// Shared encodings and LFSR helpers for the keypad typing-session controller.
package typing_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [3:0] KEY_START    = 4'hF;
  localparam logic [3:0] KEY_ABORT    = 4'hE;
  // Taps 8,6,5,4 expressed as bit positions 7,5,4,3.
  localparam logic [7:0] LFSR_TAPS    = 8'hB8;
  localparam logic [7:0] DEFAULT_SEED = 8'hA5;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

  // Folds the low nibble into 0..9 (10..15 map to 0..5).
  function automatic logic [3:0] lfsr_digit(input logic [7:0] s);
    logic [3:0] v;
    v = s[3:0];
    return (v < 4'd10) ? v : v - 4'd10;
  endfunction

endpackage

// File: rtl/typing_session_ctrl_lfsr.sv
// Pseudo-random target digit source: 8-bit Fibonacci LFSR with load/step and registered digit.
module digit_lfsr
  import typing_pkg::*;
#(
  parameter logic [7:0] SEED = DEFAULT_SEED
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic       i_step,
  output logic [3:0] o_digit
);

  logic [7:0] r_lfsr;
  logic [3:0] r_digit;
  logic [7:0] w_next;

  assign w_next = lfsr_next(r_lfsr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr  <= SEED;
      r_digit <= '0;
    end else if (i_load) begin
      r_lfsr  <= SEED;
      r_digit <= lfsr_digit(SEED);
    end else if (i_step) begin
      r_lfsr  <= w_next;
      r_digit <= lfsr_digit(w_next);
    end
  end

  assign o_digit = r_digit;

endmodule

// File: rtl/typing_session_ctrl.sv
// Keypad typing-test session sequencer: targets, scoring and ms timing.
// Optional build macro TYPING_STRICT_EN: wrong digits do not advance the target.
module typing_session_ctrl
  import typing_pkg::*;
#(
  parameter int         SEQ_LEN  = 16,
  parameter int         TICK_DIV = 100_000,
  parameter int         TIME_W   = 16,
  parameter logic [7:0] SEED     = DEFAULT_SEED,
  localparam int        PW       = $clog2(SEQ_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        key_code,
  input  logic              key_held,
  output logic [3:0]        target_digit,
  output logic [PW-1:0]     position,
  output logic [PW-1:0]     correct_cnt,
  output logic [PW-1:0]     error_cnt,
  output logic [TIME_W-1:0] elapsed_ms,
  output logic [1:0]        state,
  output logic              press_ok,
  output logic              press_err
);

  localparam int             PSW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]  LAST_POS  = PW'(SEQ_LEN - 1);
  localparam logic [PSW-1:0] PRESC_MAX = PSW'(TICK_DIV - 1);
`ifdef TYPING_STRICT_EN
  localparam logic ADV_ON_ERR = 1'b0;
`else
  localparam logic ADV_ON_ERR = 1'b1;
`endif

  state_t              r_state, w_state_nxt;
  logic                r_key_held_q;
  logic [PW-1:0]       r_position, r_correct, r_error;
  logic [TIME_W-1:0]   r_elapsed;
  logic [PSW-1:0]      r_presc;
  logic                r_ok, r_err;
  logic [3:0]          w_target;
  logic                w_kp, w_is_digit, w_match, w_tick;
  logic                w_start, w_ok, w_err, w_adv, w_final;

  assign w_kp       = key_held & ~r_key_held_q;
  assign w_is_digit = (key_code <= 4'd9);
  assign w_match    = (key_code == w_target);
  assign w_tick     = (r_state == ST_RUN) && (r_presc == PRESC_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_ok        = 1'b0;
    w_err       = 1'b0;
    w_adv       = 1'b0;
    w_final     = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_kp) begin
          if (w_is_digit) begin
            w_ok    = w_match;
            w_err   = ~w_match;
            w_adv   = w_match | ADV_ON_ERR;
            w_final = w_adv && (r_position == LAST_POS);
            if (w_final) w_state_nxt = ST_DONE;
          end else if (key_code == KEY_ABORT) begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      ST_IDLE, ST_DONE: begin
        if (w_kp && key_code == KEY_START) begin
          w_start     = 1'b1;
          w_state_nxt = ST_RUN;
        end else if (w_kp && key_code == KEY_ABORT) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Counters, prescaler and score pulses; a tick on the final-press edge still counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_key_held_q <= 1'b1;
      r_position   <= '0;
      r_correct    <= '0;
      r_error      <= '0;
      r_elapsed    <= '0;
      r_presc      <= '0;
      r_ok         <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_key_held_q <= key_held;
      r_ok         <= w_ok;
      r_err        <= w_err;
      if (w_start) begin
        r_position <= '0;
        r_correct  <= '0;
        r_error    <= '0;
        r_elapsed  <= '0;
        r_presc    <= '0;
      end else begin
        if (r_state == ST_RUN) begin
          r_presc <= w_tick ? '0 : r_presc + 1'b1;
          if (w_tick && r_elapsed != '1) r_elapsed <= r_elapsed + 1'b1;
        end
        if (w_ok) r_correct <= r_correct + 1'b1;
        if (w_err && r_error != '1) r_error <= r_error + 1'b1;
        if (w_adv) r_position <= r_position + 1'b1;
      end
    end
  end

  digit_lfsr #(.SEED(SEED)) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_start),
    .i_step  (w_adv & ~w_final),
    .o_digit (w_target)
  );

  assign target_digit = w_target;
  assign position     = r_position;
  assign correct_cnt  = r_correct;
  assign error_cnt    = r_error;
  assign elapsed_ms   = r_elapsed;
  assign state        = r_state;
  assign press_ok     = r_ok;
  assign press_err    = r_err;

endmodule

// File: doc/typing_session_ctrl.md
# typing_session_ctrl

Sequences one keypad typing-test session on top of the keypad decoder's `dec_out`/`button_pressed` pair. Generates a pseudo-random digit target sequence, edge-detects key presses, scores each press against the current target digit, and times the session in milliseconds. Its outputs drive the display/scoreboard logic.

## Interface
- `SEQ_LEN`, 16: number of target digits per session (2..255).
- `TICK_DIV`, 100_000: clock cycles per 1 ms tick (100 MHz clock).
- `TIME_W`, 16: width of elapsed-ms counter.
- `SEED`, 8'hA5: LFSR load value on reset and on every session start; nonzero.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `key_code`  in  4  decoder key value (0–9 digits, A–D letters, E = abort, F = start).
- `key_held`  in  1  decoder `button_pressed` level; a press is its 0→1 transition.
- `target_digit`  out  4  digit the user must type now (0–9).
- `position`  out  PW  index of current target, PW = $clog2(SEQ_LEN+1).
- `correct_cnt`  out  PW  correct presses this session.
- `error_cnt`  out  PW  wrong presses this session; saturates at all-ones.
- `elapsed_ms`  out  TIME_W  ms since session start; saturates at all-ones.
- `state`  out  2  IDLE=0, RUN=1, DONE=2.
- `press_ok` / `press_err`  out  1  one-cycle score pulses.

## Operation
- Press event `kp` = `key_held` & ~`key_held_q`, where `key_held_q` is a registered copy; `key_code` is sampled in the same cycle as `kp`.
- Reset: state IDLE; all counts, `position`, `elapsed_ms`, `target_digit`, and pulses are 0; LFSR = SEED; `key_held_q` = 1, so a key held through reset release is not a press.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4, shifting one step per digit advance. Digit derivation: v = lfsr[3:0]; digit = v < 10 ? v : v − 10.
- IDLE: `kp` with F → reload LFSR = SEED, clear counts/position/elapsed/tick prescaler, load `target_digit` from SEED, go to RUN. All other keys are ignored.
- RUN, `kp` with code 0–9:
  - Equals `target_digit`: `press_ok`, `correct_cnt`+1, advance.
  - Otherwise: `press_err`, `error_cnt`+1 (saturating). Advance unless strict mode (see Configuration).
  - Advance: `position`+1, LFSR step, `target_digit` = new digit. When `position` reaches SEQ_LEN, go to DONE instead; `target_digit` holds its value.
- RUN, `kp` with E: abort to IDLE; counts and elapsed are retained for display. Codes A–D and F are ignored in RUN.
- DONE: outputs frozen. `kp` with F starts a new session, exactly as from IDLE. `kp` with E goes to IDLE.
- `elapsed_ms` increments on every prescaler wrap (TICK_DIV cycles) while in RUN only.

## Timing
- All outputs are registered. `kp` in cycle n produces score pulse, counter, position, and target updates visible at n+1.
- Transition to DONE occurs in the same edge as the final advance. `elapsed_ms` stops at that edge; a tick coincident with the final press is counted.
- Start in cycle n: RUN and the first target are visible at n+1; the first ms tick occurs TICK_DIV cycles later.
- Only one press is scored per `key_held` rising edge. A new press requires `key_held` to return to 0.
- `rst` asserted mid-session returns to reset values immediately, without waiting for a clock.

## Configuration
- `TYPING_STRICT_EN` defined: a wrong digit does not advance; `position` and `target_digit` are held until the correct digit is typed. The session therefore always ends with `correct_cnt` = SEQ_LEN.
- Not defined: a wrong digit advances, so `correct_cnt` + `error_cnt` = SEQ_LEN at DONE (absent saturation).

## Structure
- Package `typing_pkg`: state encoding (IDLE/RUN/DONE), key constants (KEY_START = 4'hF, KEY_ABORT = 4'hE), LFSR tap mask, and default SEED.
- Sub-module `digit_lfsr`: holds LFSR state with load/step inputs and a registered digit output. The prescaler and FSM stay in the top-level module.

## Test plan
- Reset with `key_held`=1, then release and press F → no press until release; after F, state=1, position=0, target = digit(SEED) = 5.
- Type all SEQ_LEN=4 targets correctly (TICK_DIV=10) → four `press_ok` pulses, correct_cnt=4, state=2, elapsed_ms frozen.
- Non-strict: one wrong digit at position 1 → `press_err`, error_cnt=1, position=2, DONE after 4 presses. Strict: position stays 1 until the correct digit is typed.
- Hold a digit key for 1000 cycles → exactly one score event.
- Press E mid-session → state=0 with counts retained. Press F → counts cleared and target = digit(SEED) again.
- Set TIME_W=4 and idle in RUN for 20 ticks → elapsed_ms saturates at 15. Assert `rst` between clock edges → outputs clear before the next edge.
